neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/neuron_sequencer_if.sv | 30 +++
 rtl/pair_buffer.sv | 29 ++
 rtl/neuron_sequencer.sv | 146 ++++++++++++++
 tb/tb_neuron_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron sequencer: operand type, FSM states, ReLU helper.
package neuron_pkg;

    typedef logic signed [7:0] data_t;

    typedef enum logic [2:0] {
        StLoad,
        StClear,
        StRun,
        StDrain,
        StOut
    } state_t;

    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned ACC_LAT_DEF = 2;

    function automatic data_t relu(input data_t v);
        return v[7] ? data_t'(0) : v;
    endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Input/accumulator/output signal bundle between the sequencer (slave) and its environment (master).
interface neuron_sequencer_if
    import neuron_pkg::*;
();
    logic  in_valid;
    logic  in_ready;
    data_t in_x;
    data_t in_w;
    logic  in_last;
    data_t bias_in;
    logic  acc_clr;
    logic  acc_en;
    data_t acc_x;
    data_t acc_w;
    data_t acc_bias;
    data_t acc_accu;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;

    modport master (
        output in_valid, in_x, in_w, in_last, bias_in, acc_accu, out_ready,
        input  in_ready, acc_clr, acc_en, acc_x, acc_w, acc_bias, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_x, in_w, in_last, bias_in, acc_accu, out_ready,
        output in_ready, acc_clr, acc_en, acc_x, acc_w, acc_bias, out_valid, out_data
    );
endinterface

// File: rtl/pair_buffer.sv
// DEPTH-entry {x, w} store: one synchronous write port, one combinational indexed read port.
module pair_buffer
    import neuron_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  data_t         i_wr_x,
    input  data_t         i_wr_w,
    input  logic [AW-1:0] i_rd_addr,
    output data_t         o_rd_x,
    output data_t         o_rd_w
);
    data_t r_mem_x [DEPTH];
    data_t r_mem_w [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem_x[i_wr_addr] <= i_wr_x;
            r_mem_w[i_wr_addr] <= i_wr_w;
        end
    end

    assign o_rd_x = r_mem_x[i_rd_addr];
    assign o_rd_w = r_mem_w[i_rd_addr];
endmodule

// File: rtl/neuron_sequencer.sv
// Buffers input/weight pairs, replays them into an external accumulator, returns the result.
// Define NEURON_SEQ_RELU_EN to clamp negative results to zero.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned ACC_LAT = ACC_LAT_DEF
) (
    input logic              clk,
    input logic              rst,
    neuron_sequencer_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ACC_LAT - 1);

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_idx;
    logic [DW-1:0]   r_drain;
    data_t           r_bias;
    logic            r_in_ready;
    logic            r_acc_clr;
    logic            r_acc_en;
    data_t           r_acc_x;
    data_t           r_acc_w;
    data_t           r_acc_bias;
    logic            r_out_valid;
    data_t           r_out_data;

    logic            w_accept;
    logic [CW-1:0]   w_count_inc;
    data_t           w_rd_x;
    data_t           w_rd_w;
    data_t           w_act;

    assign w_accept    = (r_state == StLoad) && r_in_ready && bus.in_valid;
    assign w_count_inc = r_count + CW'(1);

`ifdef NEURON_SEQ_RELU_EN
    assign w_act = relu(bus.acc_accu);
`else
    assign w_act = bus.acc_accu;
`endif

    pair_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_pair_buffer (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_count[AW-1:0]),
        .i_wr_x    (bus.in_x),
        .i_wr_w    (bus.in_w),
        .i_rd_addr (r_idx[AW-1:0]),
        .o_rd_x    (w_rd_x),
        .o_rd_w    (w_rd_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StLoad;
            r_count     <= '0;
            r_idx       <= '0;
            r_drain     <= '0;
            r_bias      <= '0;
            r_in_ready  <= 1'b1;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_acc_x     <= '0;
            r_acc_w     <= '0;
            r_acc_bias  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                StLoad: begin
                    if (w_accept) begin
                        r_count <= w_count_inc;
                        // A full buffer closes the evaluation even without in_last.
                        if (bus.in_last || (w_count_inc == DEPTH_C)) begin
                            r_bias     <= bus.bias_in;
                            r_in_ready <= 1'b0;
                            r_acc_clr  <= 1'b1;
                            r_idx      <= '0;
                            r_state    <= StClear;
                        end
                    end
                end
                StClear: begin
                    r_acc_clr  <= 1'b0;
                    r_acc_en   <= 1'b1;
                    r_acc_x    <= w_rd_x;
                    r_acc_w    <= w_rd_w;
                    r_acc_bias <= r_bias;
                    r_idx      <= CW'(1);
                    r_state    <= StRun;
                end
                StRun: begin
                    if (r_idx < r_count) begin
                        r_acc_x    <= w_rd_x;
                        r_acc_w    <= w_rd_w;
                        r_acc_bias <= '0;
                        r_idx      <= r_idx + CW'(1);
                    end else begin
                        r_acc_en   <= 1'b0;
                        r_acc_x    <= '0;
                        r_acc_w    <= '0;
                        r_acc_bias <= '0;
                        r_drain    <= '0;
                        r_state    <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_out_data  <= w_act;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_count     <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StLoad;
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.acc_clr   = r_acc_clr;
    assign bus.acc_en    = r_acc_en;
    assign bus.acc_x     = r_acc_x;
    assign bus.acc_w     = r_acc_w;
    assign bus.acc_bias  = r_acc_bias;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a two-stage reference accumulator (ACC_LAT = 2).
module tb_neuron_sequencer;
    import neuron_pkg::*;

    logic clk;
    logic rst;
    neuron_sequencer_if bus ();

    neuron_sequencer #(
        .DEPTH   (8),
        .ACC_LAT (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference accumulator: sum registered on acc_en, then one more stage -> valid 2 cycles later.
    data_t r_sum;
    data_t r_sum_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_sum_q <= '0;
        end else begin
            if (bus.acc_clr)     r_sum <= '0;
            else if (bus.acc_en) r_sum <= r_sum + bus.acc_x * bus.acc_w + bus.acc_bias;
            r_sum_q <= r_sum;
        end
    end
    assign bus.acc_accu = r_sum_q;

    int n_checks = 0;
    int n_errors = 0;
    int mon_n    = 0;
    int mon_clr  = 0;
    int bad_idle = 0;
    int mon_x [16];
    int mon_w [16];
    int mon_b [16];
    int jx [8];
    int jw [8];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.acc_en) begin
                if (mon_n < 16) begin
                    mon_x[mon_n] = int'(bus.acc_x);
                    mon_w[mon_n] = int'(bus.acc_w);
                    mon_b[mon_n] = int'(bus.acc_bias);
                end
                mon_n = mon_n + 1;
            end else if (bus.acc_x != 0 || bus.acc_w != 0 || bus.acc_bias != 0) begin
                bad_idle = bad_idle + 1;
            end
            if (bus.acc_clr) mon_clr = mon_clr + 1;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic feed(input int n, input bit has_last, input int bias);
        mon_n   = 0;
        mon_clr = 0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = data_t'(jx[i]);
            bus.in_w     = data_t'(jw[i]);
            bus.in_last  = has_last && (i == n - 1);
            bus.bias_in  = data_t'(bias);
            @(negedge clk);
            check_eq($sformatf("in_ready_beat%0d", i), int'(bus.in_ready), 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_valid"}, int'(bus.out_valid), 1);
        check_eq({tag, "_data"}, int'(bus.out_data), exp);
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    int held;
    int seen;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.in_last   = 1'b0;
        bus.bias_in   = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        check_eq("rst_in_ready", int'(bus.in_ready), 1);
        check_eq("rst_acc_clr", int'(bus.acc_clr), 0);
        check_eq("rst_acc_en", int'(bus.acc_en), 0);
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_out_data", int'(bus.out_data), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single pair: 5*2 + 1 = 11
        jx[0] = 5; jw[0] = 2;
        feed(1, 1'b1, 1);
        wait_out("single", 11);
        check_eq("single_beats", mon_n, 1);
        check_eq("single_clr", mon_clr, 1);
        check_eq("single_x0", mon_x[0], 5);
        check_eq("single_w0", mon_w[0], 2);
        check_eq("single_b0", mon_b[0], 1);
        take_out();

        // Three pairs: 2 + 12 - 10 + 3 = 7
        jx[0] = 1; jw[0] = 2;
        jx[1] = 3; jw[1] = 4;
        jx[2] = -2; jw[2] = 5;
        feed(3, 1'b1, 3);
        wait_out("three", 7);
        check_eq("three_beats", mon_n, 3);
        check_eq("three_x1", mon_x[1], 3);
        check_eq("three_w2", mon_w[2], 5);
        check_eq("three_x2", mon_x[2], -2);
        check_eq("three_b0", mon_b[0], 3);
        check_eq("three_b1", mon_b[1], 0);
        check_eq("three_b2", mon_b[2], 0);
        take_out();

        // Eight pairs without in_last: full buffer acts as last
        for (int i = 0; i < 8; i++) begin
            jx[i] = 1;
            jw[i] = 1;
        end
        feed(8, 1'b0, 0);
        @(negedge clk);
        check_eq("full_in_ready", int'(bus.in_ready), 0);
        wait_out("full", 8);
        check_eq("full_beats", mon_n, 8);
        take_out();

        // Negative product, ReLU-dependent
        jx[0] = -3; jw[0] = 4;
        feed(1, 1'b1, 0);
`ifdef NEURON_SEQ_RELU_EN
        wait_out("neg", 0);
`else
        wait_out("neg", -12);
`endif

        // Back-pressure in OUT, with junk offered on the input side
        held = int'(bus.out_data);
        bus.in_valid = 1'b1;
        bus.in_x     = 8'sd100;
        bus.in_w     = 8'sd100;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("hold_valid%0d", i), int'(bus.out_valid), 1);
            check_eq($sformatf("hold_data%0d", i), int'(bus.out_data), held);
            check_eq($sformatf("hold_in_ready%0d", i), int'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        take_out();
        @(negedge clk);
        check_eq("release_in_ready", int'(bus.in_ready), 1);
        check_eq("release_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;

        // Reset during the second RUN cycle of a three-pair job
        jx[0] = 1; jw[0] = 2;
        jx[1] = 3; jw[1] = 4;
        jx[2] = -2; jw[2] = 5;
        feed(3, 1'b1, 3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("midrun_acc_en", int'(bus.acc_en), 1);
        rst = 1'b1;
        #1;
        check_eq("midrun_rst_in_ready", int'(bus.in_ready), 1);
        check_eq("midrun_rst_acc_en", int'(bus.acc_en), 0);
        check_eq("midrun_rst_acc_clr", int'(bus.acc_clr), 0);
        check_eq("midrun_rst_acc_x", int'(bus.acc_x), 0);
        check_eq("midrun_rst_acc_w", int'(bus.acc_w), 0);
        check_eq("midrun_rst_acc_bias", int'(bus.acc_bias), 0);
        check_eq("midrun_rst_out_valid", int'(bus.out_valid), 0);
        check_eq("midrun_rst_out_data", int'(bus.out_data), 0);
        #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check_eq("midrun_no_valid", seen, 0);
        @(posedge clk);
        #1;
        jx[0] = 5; jw[0] = 2;
        feed(1, 1'b1, 1);
        wait_out("after_rst", 11);
        take_out();

        check_eq("idle_operands_zero", bad_idle, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
